// File: rtl/ncu_sii_pkg.sv
// Shared types and helpers for the SII-to-NCU inbound receiver.
// Holds the bus widths, the receive FSM states, the packet record and the parity helper.
package ncu_sii_pkg;

    localparam int SII_NCU_DW     = 32;
    localparam int SII_NCU_PW     = 2;
    localparam int PLD_BEATS_DFLT = 4;

    typedef enum logic [1:0] {
        IDLE,
        GNT,
        HDR,
        PLD
    } rcv_state_e;

    typedef struct packed {
        logic [SII_NCU_DW-1:0]                hdr;
        logic [PLD_BEATS_DFLT*SII_NCU_DW-1:0] pld;
        logic                                 perr;
    } pkt_t;

    function automatic logic par16_even(input logic [15:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ncu_sii_pkt_fifo.sv
// Synchronous packet FIFO: simultaneous push/pop at any occupancy, pointers wrap modulo DEPTH.
// The head entry is presented directly from the storage registers.
module ncu_sii_pkt_fifo
    import ncu_sii_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = pkt_t,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  T              din,
    input  logic          pop,
    output T              dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ncu_sii_rcv.sv
// NCU receiver for SII Mondo/PIO completions: grant, header + payload capture, parity check,
// packet FIFO and valid/ready delivery to the NCU core.
module ncu_sii_rcv
    import ncu_sii_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PLD_BEATS  = PLD_BEATS_DFLT,
    parameter int PERR_CNT_W = 8
) (
    input  logic                            iol2clk,
    input  logic                            rst,
    input  logic                            sii_ncu_req,
    input  logic [SII_NCU_DW-1:0]           sii_ncu_data,
    input  logic [SII_NCU_PW-1:0]           sii_ncu_dparity,
    output logic                            ncu_sii_gnt,
    output logic                            pkt_vld,
    input  logic                            pkt_rdy,
    output logic [SII_NCU_DW-1:0]           pkt_hdr,
    output logic [PLD_BEATS*SII_NCU_DW-1:0] pkt_pld,
    output logic                            pkt_perr,
    output logic [PERR_CNT_W-1:0]           perr_cnt,
    output logic                            rcv_busy
);

    localparam int BW = (PLD_BEATS > 1) ? $clog2(PLD_BEATS) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [SII_NCU_DW-1:0]           hdr;
        logic [PLD_BEATS*SII_NCU_DW-1:0] pld;
        logic                            perr;
    } rcv_pkt_t;

    rcv_state_e                      state;
    rcv_state_e                      state_nxt;
    logic [BW-1:0]                   beat;
    logic                            last_beat;
    logic                            beat_err;
    logic                            pkt_done;
    logic [SII_NCU_DW-1:0]           hdr_q;
    logic [PLD_BEATS*SII_NCU_DW-1:0] pld_q;
    logic [PLD_BEATS*SII_NCU_DW-1:0] pld_nxt;
    logic                            perr_q;
    rcv_pkt_t                        push_pkt;
    rcv_pkt_t                        head_pkt;
    logic                            fifo_push;
    logic                            fifo_pop;
    logic                            fifo_full;
    logic                            fifo_empty;
    logic [CW-1:0]                   fifo_cnt;

    assign last_beat = (beat == BW'(PLD_BEATS - 1));
    assign beat_err  = (par16_even(sii_ncu_data[15:0])  != sii_ncu_dparity[0]) ||
                       (par16_even(sii_ncu_data[31:16]) != sii_ncu_dparity[1]);

    always_ff @(posedge iol2clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // The in-flight packet keeps its slot, so only the committed occupancy gates a new grant.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sii_ncu_req && (int'(fifo_cnt) < FIFO_DEPTH)) state_nxt = GNT;
            GNT:     state_nxt = HDR;
            HDR:     state_nxt = PLD;
            PLD:     if (last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ncu_sii_gnt = (state == GNT);
        rcv_busy    = (state != IDLE);
        pkt_done    = (state == PLD) && last_beat;
    end

    always_comb begin
        pld_nxt = pld_q;
        pld_nxt[int'(beat)*SII_NCU_DW +: SII_NCU_DW] = sii_ncu_data;
        push_pkt.hdr  = hdr_q;
        push_pkt.pld  = pld_nxt;
        push_pkt.perr = perr_q | beat_err;
    end

    always_ff @(posedge iol2clk) begin
        if (state == HDR) hdr_q <= sii_ncu_data;
        if (state == PLD) pld_q <= pld_nxt;
    end

    always_ff @(posedge iol2clk) begin
        if (rst) begin
            beat     <= '0;
            perr_q   <= 1'b0;
            perr_cnt <= '0;
        end else begin
            case (state)
                HDR: begin
                    beat   <= '0;
                    perr_q <= 1'b0;
                end
                PLD: begin
                    beat   <= beat + 1'b1;
                    perr_q <= perr_q | beat_err;
                end
                default: ;
            endcase
            if (pkt_done && push_pkt.perr && (perr_cnt != '1)) perr_cnt <= perr_cnt + 1'b1;
        end
    end

    assign fifo_pop  = pkt_vld && pkt_rdy;
    assign fifo_push = pkt_done && (!fifo_full || fifo_pop);

    ncu_sii_pkt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (rcv_pkt_t)
    ) u_pkt_fifo (
        .clk   (iol2clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (push_pkt),
        .pop   (fifo_pop),
        .dout  (head_pkt),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // The error flag is gated so it reads 0 whenever no packet is presented.
    assign pkt_vld  = !fifo_empty;
    assign pkt_hdr  = head_pkt.hdr;
    assign pkt_pld  = head_pkt.pld;
    assign pkt_perr = pkt_vld && head_pkt.perr;

endmodule

// File: tb/tb_ncu_sii_rcv.sv
// Self-checking bench for ncu_sii_rcv: an SII driver, an NCU-side drain and a packet-queue reference model.
module tb_ncu_sii_rcv;

    localparam int DEPTH = 4;
    localparam int BEATS = 4;
    localparam int PCW   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req = 1'b0;
    logic [31:0]      data = '0;
    logic [1:0]       dpar = '0;
    logic             gnt;
    logic             vld;
    logic             rdy = 1'b0;
    logic [31:0]      hdr;
    logic [127:0]     pld;
    logic             perr;
    logic [PCW-1:0]   cnt;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0]  hdr;
        logic [127:0] pld;
        logic         perr;
    } exp_pkt_t;

    exp_pkt_t       exp_q[$];
    logic [PCW-1:0] exp_cnt = '0;
    int             gnt_q[$];

    ncu_sii_rcv #(
        .FIFO_DEPTH (DEPTH),
        .PLD_BEATS  (BEATS),
        .PERR_CNT_W (PCW)
    ) dut (
        .iol2clk         (clk),
        .rst             (rst),
        .sii_ncu_req     (req),
        .sii_ncu_data    (data),
        .sii_ncu_dparity (dpar),
        .ncu_sii_gnt     (gnt),
        .pkt_vld         (vld),
        .pkt_rdy         (rdy),
        .pkt_hdr         (hdr),
        .pkt_pld         (pld),
        .pkt_perr        (perr),
        .perr_cnt        (cnt),
        .rcv_busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (gnt === 1'b1) gnt_q.push_back(cyc);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] good_par(input logic [31:0] d);
        return {^d[31:16], ^d[15:0]};
    endfunction

    function automatic logic [127:0] rand_pld();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
        gnt_q.delete();
    endtask

    // SII side: request, wait for the grant, drive header then payload beats one per cycle.
    // flip[2k+1:2k] corrupts the parity of beat k; abort_beat >= 0 pulses rst during that beat.
    task automatic sii_send(input logic [31:0] h, input logic [127:0] p, input logic [7:0] flip,
                            input bit hold_req, input bit bad_hdr, input int abort_beat,
                            output int req_cyc, output int gnt_cyc);
        int n;
        n = 0;
        gnt_cyc = -1;
        @(negedge clk);
        req = 1'b1;
        req_cyc = cyc;
        while (gnt !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (gnt !== 1'b1) begin
            failures++;
            $display("FAIL grant_timeout: gnt=%b after %0d cycles, required 1", gnt, n);
            req = 1'b0;
            return;
        end
        gnt_cyc = cyc;
        if (!hold_req) req = 1'b0;
        @(negedge clk);
        data = h;
        dpar = good_par(h) ^ (bad_hdr ? 2'b11 : 2'b00);
        for (int k = 0; k < BEATS; k++) begin
            @(negedge clk);
            data = p[32*k +: 32];
            dpar = good_par(p[32*k +: 32]) ^ flip[2*k +: 2];
            if (k == abort_beat) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        exp_q.push_back('{h, p, |flip});
        if ((|flip) && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    endtask

    // NCU side: accept n packets in order and compare each with the model queue.
    task automatic drain(input int n, input bit rand_stall, output int last_cyc);
        int got;
        int budget;
        got = 0;
        budget = 0;
        last_cyc = -1;
        while (got < n && budget < n * 40 + 50) begin
            @(negedge clk);
            budget++;
            rdy = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (vld === 1'b1 && rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL pop_unexpected: pkt_vld=1 hdr=%h, required no packet", hdr);
                end else begin
                    exp_pkt_t e;
                    e = exp_q.pop_front();
                    if (hdr !== e.hdr || pld !== e.pld || perr !== e.perr) begin
                        failures++;
                        $display("FAIL pkt_content: got hdr=%h pld=%h perr=%b, required hdr=%h pld=%h perr=%b",
                                 hdr, pld, perr, e.hdr, e.pld, e.perr);
                    end
                end
                got++;
                last_cyc = cyc;
            end
        end
        if (got < n) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d packets, required %0d", got, n);
        end
        @(negedge clk);
        rdy = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gnt  !== 1'b0) begin failures++; $display("FAIL reset_gnt: got %b, required 0", gnt); end
        checks++; if (vld  !== 1'b0) begin failures++; $display("FAIL reset_vld: got %b, required 0", vld); end
        checks++; if (perr !== 1'b0) begin failures++; $display("FAIL reset_perr: got %b, required 0", perr); end
        checks++; if (cnt  !== '0)   begin failures++; $display("FAIL reset_cnt: got %0d, required 0", cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", busy); end
    endtask

    task automatic test_single();
        int rc, gc, lc;
        gnt_q.delete();
        sii_send(32'hA5A5_0001, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                 8'h00, 1'b0, 1'b0, -1, rc, gc);
        checks++; if (gc !== rc + 1) begin failures++; $display("FAIL single_gnt_cycle: got %0d, required %0d", gc, rc + 1); end
        checks++; if (vld !== 1'b0) begin failures++; $display("FAIL single_vld_early: got %b at cycle %0d, required 0", vld, cyc); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_last_beat: got %b, required 1", busy); end
        @(negedge clk);
        checks++; if (vld !== 1'b1) begin failures++; $display("FAIL single_vld_latency: got %b at cycle %0d, required 1 at %0d", vld, cyc, rc + 7); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_clear: got %b, required 0", busy); end
        checks++; if (pld !== 128'h44444444_33333333_22222222_11111111) begin failures++; $display("FAIL single_pld: got %h, required 44444444333333332222222211111111", pld); end
        checks++; if (perr !== 1'b0) begin failures++; $display("FAIL single_perr: got %b, required 0", perr); end
        checks++; if (gnt_q.size() != 1) begin failures++; $display("FAIL single_gnt_count: got %0d grants, required 1", gnt_q.size()); end
        drain(1, 1'b0, lc);
        checks++; if (cnt !== exp_cnt) begin failures++; $display("FAIL single_cnt: got %0d, required %0d", cnt, exp_cnt); end
    endtask

    task automatic test_parity();
        int rc, gc, lc;
        sii_send($urandom, rand_pld(), 8'b0010_0000, 1'b0, 1'b0, -1, rc, gc);
        sii_send($urandom, rand_pld(), 8'h00, 1'b0, 1'b1, -1, rc, gc);
        drain(2, 1'b0, lc);
        checks++; if (cnt !== 2'd1) begin failures++; $display("FAIL parity_cnt: got %0d, required 1", cnt); end
    endtask

    task automatic test_back_to_back();
        int rc, gc, lc, rc0;
        rc0 = 0;
        gnt_q.delete();
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    sii_send($urandom, rand_pld(), 8'h00, 1'b1, 1'b0, -1, rc, gc);
                    if (i == 0) rc0 = rc;
                end
                req = 1'b0;
            end
            drain(3, 1'b0, lc);
        join
        checks++;
        if (gnt_q.size() != 3) begin
            failures++;
            $display("FAIL b2b_gnt_count: got %0d grants, required 3", gnt_q.size());
        end else begin
            checks++; if (gnt_q[0] != rc0 + 1) begin failures++; $display("FAIL b2b_first_gnt: got %0d, required %0d", gnt_q[0], rc0 + 1); end
            checks++; if (gnt_q[1] - gnt_q[0] != 7) begin failures++; $display("FAIL b2b_gap1: got %0d, required 7", gnt_q[1] - gnt_q[0]); end
            checks++; if (gnt_q[2] - gnt_q[1] != 7) begin failures++; $display("FAIL b2b_gap2: got %0d, required 7", gnt_q[2] - gnt_q[1]); end
        end
    endtask

    task automatic test_backpressure();
        int rc, gc, gc5, pop_cyc, lc;
        gc5 = -1;
        pop_cyc = -1;
        rdy = 1'b0;
        gnt_q.delete();
        for (int i = 0; i < DEPTH; i++) sii_send($urandom, rand_pld(), 8'h00, 1'b0, 1'b0, -1, rc, gc);
        fork
            sii_send($urandom, rand_pld(), 8'h00, 1'b0, 1'b0, -1, rc, gc5);
            begin
                repeat (6) @(negedge clk);
                checks++; if (gnt_q.size() != DEPTH) begin failures++; $display("FAIL full_gnt_held: got %0d grants, required %0d", gnt_q.size(), DEPTH); end
                checks++; if (gnt !== 1'b0) begin failures++; $display("FAIL full_gnt_low: got %b, required 0", gnt); end
                drain(1, 1'b0, pop_cyc);
            end
        join
        checks++; if (gc5 != pop_cyc + 2) begin failures++; $display("FAIL full_resume: grant at %0d, required %0d", gc5, pop_cyc + 2); end
        drain(DEPTH, 1'b0, lc);
        checks++; if (vld !== 1'b0) begin failures++; $display("FAIL full_drained: pkt_vld=%b, required 0", vld); end
    endtask

    task automatic test_reset_mid();
        int rc, gc, lc;
        rdy = 1'b0;
        sii_send($urandom, rand_pld(), 8'h00, 1'b0, 1'b0, -1, rc, gc);
        sii_send($urandom, rand_pld(), 8'b0000_0001, 1'b0, 1'b0, 1, rc, gc);
        exp_q.delete();
        exp_cnt = '0;
        gnt_q.delete();
        checks++; if (vld  !== 1'b0) begin failures++; $display("FAIL midrst_vld: got %b, required 0", vld); end
        checks++; if (gnt  !== 1'b0) begin failures++; $display("FAIL midrst_gnt: got %b, required 0", gnt); end
        checks++; if (cnt  !== '0)   begin failures++; $display("FAIL midrst_cnt: got %0d, required 0", cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        repeat (3) @(negedge clk);
        checks++; if (gnt_q.size() != 0) begin failures++; $display("FAIL midrst_spurious_gnt: got %0d grants, required 0", gnt_q.size()); end
        sii_send($urandom, rand_pld(), 8'h00, 1'b0, 1'b0, -1, rc, gc);
        drain(1, 1'b0, lc);
    endtask

    task automatic test_saturation();
        int rc, gc, lc;
        for (int i = 0; i < 5; i++) begin
            sii_send($urandom, rand_pld(), 8'(1 << $urandom_range(0, 7)), 1'b0, 1'b0, -1, rc, gc);
            drain(1, 1'b0, lc);
            checks++; if (cnt !== exp_cnt) begin failures++; $display("FAIL sat_cnt_%0d: got %0d, required %0d", i, cnt, exp_cnt); end
        end
        checks++; if (cnt !== 2'b11) begin failures++; $display("FAIL sat_final: got %0d, required 3", cnt); end
    endtask

    task automatic test_random();
        int rc, gc, lc;
        do_reset();
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    sii_send($urandom, rand_pld(),
                             ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
                             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, rc, gc);
                end
                req = 1'b0;
            end
            drain(20, 1'b1, lc);
        join
        checks++; if (cnt !== exp_cnt) begin failures++; $display("FAIL random_cnt: got %0d, required %0d", cnt, exp_cnt); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL random_leftover: %0d packets not delivered, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ncu_sii_rcv.md
Name: ncu_sii_rcv

Overview:
- NCU-side receiver for the inbound SII-to-NCU path: Mondo interrupts and PIO completions.
- Arbitrates the SII request with a single-cycle grant, then captures one header beat and four payload beats from the 32-bit bus.
- Checks payload parity and assembles each packet into a small FIFO.
- Presents complete packets to the NCU core through a valid/ready interface.

Parameters:
- FIFO_DEPTH, 4: number of assembled packets buffered; must be ≥1.
- PLD_BEATS, 4: payload beats per packet, each 32 bits.
- PERR_CNT_W, 8: width of the saturating parity-error counter.

Ports:
- iol2clk  in  1  I/O L2 clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sii_ncu_req  in  1  SII request. Level signal, held until a grant is seen.
- sii_ncu_data  in  32  header or payload beat.
- sii_ncu_dparity  in  2  even parity per payload beat: [0] covers data[15:0], [1] covers data[31:16].
- ncu_sii_gnt  out  1  single-cycle grant to SII.
- pkt_vld  out  1  FIFO head packet valid.
- pkt_rdy  in  1  NCU core accepts the head packet when pkt_vld && pkt_rdy.
- pkt_hdr  out  32  header of the head packet.
- pkt_pld  out  PLD_BEATS*32  payload; beat 0 in [31:0], beat k in [32k+31:32k].
- pkt_perr  out  1  at least one payload beat of the head packet had a parity mismatch.
- perr_cnt  out  PERR_CNT_W  saturating count of packets with pkt_perr set.
- rcv_busy  out  1  grant issued and transfer not yet complete.

Behaviour:
- Reset values: ncu_sii_gnt=0, pkt_vld=0, pkt_perr=0, perr_cnt=0, rcv_busy=0, FIFO empty, FSM in IDLE. pkt_hdr and pkt_pld are don't-care while pkt_vld=0.
- FSM states: IDLE, GNT, HDR, PLD.
- IDLE -> GNT when sii_ncu_req=1 and FIFO occupancy < FIFO_DEPTH, both sampled at the same edge.
  - The in-flight packet reserves its slot: a pop during a transfer frees space, but no second grant is issued until the transfer ends.
- GNT: ncu_sii_gnt=1 for exactly this cycle (cycle T); rcv_busy=1. Next state is HDR.
- HDR: cycle T+1. Capture sii_ncu_data as the header; no parity check. Next state is PLD with beat counter=0.
- PLD: cycles T+2 .. T+1+PLD_BEATS.
  - Capture beat k into pld[k].
  - Per-beat error = (^data[15:0] != dparity[0]) || (^data[31:16] != dparity[1]).
  - The packet error flag ORs all per-beat errors.
  - On the last beat (counter = PLD_BEATS-1): push {hdr, pld, perr} into the FIFO at that edge, go to IDLE, and clear rcv_busy.
  - If the error flag is set, perr_cnt increments, saturating at all-ones.
- Latency: a pushed packet appears on pkt_vld at cycle T+2+PLD_BEATS (T+6 with the default) if the FIFO was empty.
- Back-to-back transfers: IDLE is entered at T+6, so the earliest next grant is cycle T+7 (req re-sampled at the T+6 edge).
- sii_ncu_req is ignored from GNT through PLD.
- FIFO:
  - Registered head output.
  - Simultaneous push and pop allowed at any occupancy, including full (pop frees the head, push writes the tail, occupancy unchanged).
  - Pointers wrap modulo FIFO_DEPTH.
  - pkt_vld stays high while occupancy > 0.
- Full FIFO: FSM remains in IDLE with ncu_sii_gnt=0 while the request is pending. Granting resumes on the first edge at which occupancy < FIFO_DEPTH.
- pkt_rdy with pkt_vld=0 has no effect.
- Reset mid-transfer: partial packet discarded, FIFO cleared, FSM to IDLE, grant low on the next cycle. SII-side recovery is outside this block.

Decomposition:
- Shared package ncu_sii_pkg holds:
  - constants SII_NCU_DW=32 and SII_NCU_PW=2;
  - the state enum {IDLE, GNT, HDR, PLD};
  - the packet struct {hdr[31:0], pld[PLD_BEATS*32-1:0], perr};
  - function par16_even.
- One sub-module, ncu_sii_pkt_fifo: a parameterised synchronous FIFO of packet structs with push, pop, full, empty and count.
- The FSM, capture registers and error counter live in the top module.

Test Plan:
- Single transfer: req=1 at cycle 0, header 0xA5A5_0001, payload 0x1111_1111..0x4444_4444 with correct parity -> gnt at cycle 1 only; pkt_vld at cycle 7; pkt_pld=0x44444444_33333333_22222222_11111111; pkt_perr=0; perr_cnt=0.
- Parity error: flip dparity[1] on payload beat 2 only -> pkt_perr=1; perr_cnt=1. The same bad data appearing on the header beat -> no error.
- Back-pressure: pkt_rdy=0, five requests -> four grants; fifth request held with gnt=0; one pop (pkt_rdy=1 for one cycle) -> fifth grant follows on the next edge; packets pop in arrival order.
- Back-to-back: req held high continuously with pkt_rdy=1 -> grants at cycles 1, 8, 15; no beat lost or shifted.
- Reset mid-payload: assert rst during payload beat 1 -> pkt_vld=0, gnt=0, perr_cnt=0; a following clean transfer is received correctly.
- Saturation: PERR_CNT_W=2 with 5 bad packets -> perr_cnt stays at 3.
